vliw_regfile: RTL and testbench
===============================

# vliw_regfile

Parametrised multi-port register file with an integrated destination scoreboard for the VLIW datapath. It replaces the fixed 8×32-bit, two-write/four-read register file. Generalisations:
- register count, data width and write/read port counts are parameters;
- write ports have a defined priority;
- same-cycle write-to-read bypass is optional;
- an optional hard-wired zero register is available;
- per-register busy bits let decode stall on operands still in flight.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W
- NUM_WR, 2, write ports; port 0 = ALU slot, port 1 = memory slot
- NUM_RD, 4, read ports
- BYPASS, 1, 1 = read data and rd_busy reflect same-cycle writes
- ZERO_R0, 0, 1 = register 0 reads 0, ignores writes, never busy

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  NUM_WR  write strobe per port
- wr_addr  in  NUM_WR*ADDR_W  destination per port, port k at bits [k*ADDR_W +: ADDR_W]
- wr_data  in  NUM_WR*DATA_W  write data per port
- rd_addr  in  NUM_RD*ADDR_W  source address per read port
- rd_data  out  NUM_RD*DATA_W  read data per port (combinational)
- iss_en  in  NUM_WR  reserve a destination at issue (one per slot)
- iss_addr  in  NUM_WR*ADDR_W  destination being reserved
- busy  out  NUM_REGS  registered scoreboard: bit r = write to r outstanding
- rd_busy  out  NUM_RD  operand-not-ready flag per read port (combinational)
- wr_collision  out  1  registered pulse: two or more enabled write ports targeted one register in the previous cycle

## Operation
- **Storage:** NUM_REGS × DATA_W flops. Updated on rising clk, one cycle after wr_en is sampled.
- **Write priority:** if several enabled ports target the same register, the highest-index port wins (memory over ALU). The losing data is discarded.
- **Collision flag:** the same condition sets wr_collision for exactly one cycle after the edge.
- **Read path:**
  - rd_data[i] = reg[rd_addr[i]].
  - With BYPASS=1, an enabled write to the same address in the same cycle is forwarded instead. When several ports write that address, the highest-priority port's data is forwarded.
  - All read ports are independent; any combination of identical addresses is legal.
- **Scoreboard set/clear:**
  - iss_en[k] sets busy[iss_addr[k]] at the edge.
  - wr_en[k] clears busy[wr_addr[k]] at the edge.
  - Set and clear of the same register in one cycle: set wins, so the new reservation survives.
  - Two issue ports reserving the same register: bit set once, no error.
- **Operand readiness:** rd_busy[i] = busy[rd_addr[i]], except with BYPASS=1 it is 0 when an enabled write to rd_addr[i] occurs in the same cycle.
- **ZERO_R0=1:**
  - reg[0] is constant 0;
  - writes to 0 are ignored for data, scoreboard and collision;
  - busy[0] is 0;
  - reads of 0 return 0, even with a bypass write pending.
- **Stale writeback:** a write to a non-busy register is legal and updates data normally.

## Timing
- **Reset (reset=0, asynchronous):**
  - all registers 0;
  - busy = 0;
  - wr_collision = 0.
  - rd_data and rd_busy follow combinationally: 0 for all ports.
  - Reset asserted mid-operation discards pending writes and reservations in the same instant. Release is synchronous to the next clk edge; the first edge after release may write.
- **Write-to-read latency:**
  - 0 cycles with BYPASS=1;
  - 1 cycle with BYPASS=0, data visible after the edge.
- **busy:**
  - set is visible the cycle after the iss_en edge;
  - clear is visible the cycle after the wr_en edge.
  - Issue and writeback to the same register in consecutive cycles: busy goes 0→1→0.
- **wr_collision** is a single-cycle pulse. A collision in every cycle holds it high continuously.
- **No internal state machine** beyond the flop state. No handshake back-pressure: the consumer stalls on rd_busy.

## Test plan
- **Reset and basic write/read:** reset low → all rd_data=0, busy=0. After release, wr_en=01, wr_addr[0]=5, wr_data[0]=0xDEADBEEF → rd_addr[0]=5 returns 0xDEADBEEF: same cycle with BYPASS=1, next cycle with BYPASS=0.
- **Write priority and collision:** wr_en=11, both addresses=3, data0=0x11, data1=0x22 → reg3=0x22, bypass read returns 0x22, wr_collision=1 for one cycle, then 0.
- **Scoreboard sequence:**
  - iss_en[0] with iss_addr=6 → busy[6]=1 next cycle, rd_busy=1 for reads of 6.
  - wr_en[0] to 6 → rd_busy=0 in that cycle (BYPASS=1) and busy[6]=0 next cycle.
- **Simultaneous set and clear:** busy[2]=1; same cycle iss_en[1] to 2 and wr_en[0] to 2 with 0x7 → reg2=0x7 and busy[2] stays 1.
- **ZERO_R0=1:** write 0xFFFFFFFF to 0, and iss_en to 0 → reads of 0 return 0, busy[0]=0, no collision when both ports write 0.
- **Async reset mid-run:** registers loaded with nonzero values and busy=0xF0; pull reset low between edges → all outputs 0 immediately. After release, the first write lands on the next edge.

Source files
------------

// File: rtl/vliw_regfile.sv
// vliw_regfile: parametrised multi-port register file with per-register busy scoreboard,
// priority-resolved writes, optional same-cycle bypass and optional hard-wired zero register.
module vliw_regfile #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int NUM_WR  = 2,
  parameter int NUM_RD  = 4,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  input  logic [NUM_WR-1:0]          iss_en_i,
  input  logic [NUM_WR*ADDR_W-1:0]   iss_addr_i,
  output logic [(2**ADDR_W)-1:0]     busy_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  output logic                       wr_collision_o
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d, wr_val;
  logic [NUM_REGS-1:0] busy_q, busy_d, wr_hit, wr_multi, iss_set;
  logic coll_q, coll_d;

  // Ports are scanned in ascending order so the highest-index writer wins.
  always_comb begin
    wr_hit = '0;
    wr_multi = '0;
    iss_set = '0;
    wr_val = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en_i[k] && wr_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          wr_multi[r] = wr_hit[r];
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data_i[k*DATA_W +: DATA_W];
        end
        if (iss_en_i[k] && iss_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) iss_set[r] = 1'b1;
      end
    end
    if (ZERO_R0) begin
      wr_hit[0] = 1'b0;
      wr_multi[0] = 1'b0;
      iss_set[0] = 1'b0;
      wr_val[0] = '0;
    end
    for (int r = 0; r < NUM_REGS; r++) regs_d[r] = wr_hit[r] ? wr_val[r] : regs_q[r];
    // A new reservation outlives a writeback to the same register in the same cycle.
    busy_d = (busy_q & ~wr_hit) | iss_set;
    coll_d = |wr_multi;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '0;
      busy_q <= '0;
      coll_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      coll_q <= coll_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic fwd;
    assign a = rd_addr_i[i*ADDR_W +: ADDR_W];
    assign fwd = BYPASS && rst_ni && wr_hit[a];
    assign rd_data_o[i*DATA_W +: DATA_W] = fwd ? wr_val[a] : regs_q[a];
    assign rd_busy_o[i] = !fwd && busy_q[a];
  end

  assign busy_o = busy_q;
  assign wr_collision_o = coll_q;
endmodule

// File: tb/tb_vliw_regfile.sv
// tb_vliw_regfile: scoreboard bench driving one stimulus stream into bypass, no-bypass and zero-r0 variants.
module tb_vliw_regfile;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] wr_en = '0, iss_en = '0;
  logic [5:0] wr_addr = '0, iss_addr = '0;
  logic [63:0] wr_data = '0;
  logic [11:0] rd_addr = '0;
  logic [127:0] b_rd, n_rd, z_rd;
  logic [7:0] b_busy, n_busy, z_busy;
  logic [3:0] b_rdb, n_rdb, z_rdb;
  logic b_col, n_col, z_col;
  logic [127:0] sb[$];
  logic [127:0] e;
  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  vliw_regfile u_b (.clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(b_rd), .iss_en_i(iss_en), .iss_addr_i(iss_addr), .busy_o(b_busy),
    .rd_busy_o(b_rdb), .wr_collision_o(b_col));
  vliw_regfile #(.BYPASS(1'b0)) u_n (.clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(n_rd), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .busy_o(n_busy), .rd_busy_o(n_rdb), .wr_collision_o(n_col));
  vliw_regfile #(.ZERO_R0(1'b1)) u_z (.clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(z_rd), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .busy_o(z_busy), .rd_busy_o(z_rdb), .wr_collision_o(z_col));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    iss_en = '0;
  endtask

  task automatic test_reset();
    rd_addr = {3'd0, 3'd2, 3'd6, 3'd5};
    sb.push_back(128'h0); sb.push_back(128'h0); sb.push_back(128'h0); sb.push_back(128'h0);
    step();
    step();
    @(negedge clk);
    e = sb.pop_front(); n_tot++; if (b_rd !== e) $display("FAIL reset_rd_data: got %h expected %h", b_rd, e); else n_pass++;
    e = sb.pop_front(); n_tot++; if (b_busy !== e[7:0]) $display("FAIL reset_busy: got %h expected %h", b_busy, e[7:0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (b_rdb !== e[3:0]) $display("FAIL reset_rd_busy: got %h expected %h", b_rdb, e[3:0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (b_col !== e[0]) $display("FAIL reset_collision: got %b expected %b", b_col, e[0]); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    wr_en = 2'b01; wr_addr[2:0] = 3'd5; wr_data[31:0] = 32'hDEADBEEF;
    sb.push_back(128'hDEADBEEF); sb.push_back(128'h0);
    @(negedge clk);
    e = sb.pop_front(); n_tot++; if (b_rd[31:0] !== e[31:0]) $display("FAIL bypass_same_cycle: got %h expected %h", b_rd[31:0], e[31:0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (n_rd[31:0] !== e[31:0]) $display("FAIL nobypass_same_cycle: got %h expected %h", n_rd[31:0], e[31:0]); else n_pass++;
    step();
    idle();
    sb.push_back(128'hDEADBEEF);
    @(negedge clk);
    e = sb.pop_front(); n_tot++; if (n_rd[31:0] !== e[31:0]) $display("FAIL nobypass_next_cycle: got %h expected %h", n_rd[31:0], e[31:0]); else n_pass++;
    step();
  endtask

  task automatic test_priority();
    rd_addr[2:0] = 3'd3;
    wr_en = 2'b11; wr_addr = {3'd3, 3'd3}; wr_data = {32'h22, 32'h11};
    sb.push_back(128'h22);
    @(negedge clk);
    e = sb.pop_front(); n_tot++; if (b_rd[31:0] !== e[31:0]) $display("FAIL priority_bypass: got %h expected %h", b_rd[31:0], e[31:0]); else n_pass++;
    step();
    idle();
    sb.push_back(128'h1); sb.push_back(128'h22);
    e = sb.pop_front(); n_tot++; if (b_col !== e[0]) $display("FAIL collision_pulse: got %b expected %b", b_col, e[0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (n_rd[31:0] !== e[31:0]) $display("FAIL priority_stored: got %h expected %h", n_rd[31:0], e[31:0]); else n_pass++;
    step();
    sb.push_back(128'h0);
    e = sb.pop_front(); n_tot++; if (b_col !== e[0]) $display("FAIL collision_clear: got %b expected %b", b_col, e[0]); else n_pass++;
  endtask

  task automatic test_scoreboard();
    rd_addr[5:3] = 3'd6;
    iss_en = 2'b01; iss_addr[2:0] = 3'd6;
    sb.push_back(128'h0);
    @(negedge clk);
    e = sb.pop_front(); n_tot++; if (b_rdb[1] !== e[0]) $display("FAIL busy_not_yet: got %b expected %b", b_rdb[1], e[0]); else n_pass++;
    step();
    idle();
    wr_en = 2'b01; wr_addr[2:0] = 3'd6; wr_data[31:0] = 32'h66;
    sb.push_back(128'h1); sb.push_back(128'h0); sb.push_back(128'h1);
    e = sb.pop_front(); n_tot++; if (b_busy[6] !== e[0]) $display("FAIL busy_set: got %b expected %b", b_busy[6], e[0]); else n_pass++;
    @(negedge clk);
    e = sb.pop_front(); n_tot++; if (b_rdb[1] !== e[0]) $display("FAIL rd_busy_bypass_clear: got %b expected %b", b_rdb[1], e[0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (n_rdb[1] !== e[0]) $display("FAIL rd_busy_nobypass: got %b expected %b", n_rdb[1], e[0]); else n_pass++;
    step();
    idle();
    sb.push_back(128'h0);
    e = sb.pop_front(); n_tot++; if (b_busy[6] !== e[0]) $display("FAIL busy_cleared: got %b expected %b", b_busy[6], e[0]); else n_pass++;
  endtask

  task automatic test_set_clear();
    iss_en = 2'b01; iss_addr[2:0] = 3'd2;
    step();
    idle();
    iss_en = 2'b10; iss_addr[5:3] = 3'd2;
    wr_en = 2'b01; wr_addr[2:0] = 3'd2; wr_data[31:0] = 32'h7;
    rd_addr[8:6] = 3'd2;
    sb.push_back(128'h1); sb.push_back(128'h7);
    step();
    idle();
    e = sb.pop_front(); n_tot++; if (b_busy[2] !== e[0]) $display("FAIL set_wins: got %b expected %b", b_busy[2], e[0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (b_rd[95:64] !== e[31:0]) $display("FAIL set_clear_data: got %h expected %h", b_rd[95:64], e[31:0]); else n_pass++;
    step();
  endtask

  task automatic test_zero_r0();
    rd_addr[11:9] = 3'd0;
    wr_en = 2'b11; wr_addr = '0; wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
    iss_en = 2'b01; iss_addr[2:0] = 3'd0;
    sb.push_back(128'h0); sb.push_back(128'hFFFFFFFF);
    @(negedge clk);
    e = sb.pop_front(); n_tot++; if (z_rd[127:96] !== e[31:0]) $display("FAIL zero_bypass: got %h expected %h", z_rd[127:96], e[31:0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (b_rd[127:96] !== e[31:0]) $display("FAIL r0_normal_bypass: got %h expected %h", b_rd[127:96], e[31:0]); else n_pass++;
    step();
    idle();
    sb.push_back(128'h0); sb.push_back(128'h0); sb.push_back(128'h0); sb.push_back(128'h1);
    e = sb.pop_front(); n_tot++; if (z_rd[127:96] !== e[31:0]) $display("FAIL zero_stored: got %h expected %h", z_rd[127:96], e[31:0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (z_busy[0] !== e[0]) $display("FAIL zero_busy: got %b expected %b", z_busy[0], e[0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (z_col !== e[0]) $display("FAIL zero_collision: got %b expected %b", z_col, e[0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (b_col !== e[0]) $display("FAIL r0_normal_collision: got %b expected %b", b_col, e[0]); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    wr_en = 2'b11; wr_addr = {3'd4, 3'd4}; wr_data = {32'h2, 32'h1};
    sb.push_back(128'h1); sb.push_back(128'h1); sb.push_back(128'h0);
    step();
    e = sb.pop_front(); n_tot++; if (b_col !== e[0]) $display("FAIL b2b_first: got %b expected %b", b_col, e[0]); else n_pass++;
    step();
    idle();
    e = sb.pop_front(); n_tot++; if (b_col !== e[0]) $display("FAIL b2b_held: got %b expected %b", b_col, e[0]); else n_pass++;
    step();
    e = sb.pop_front(); n_tot++; if (b_col !== e[0]) $display("FAIL b2b_drop: got %b expected %b", b_col, e[0]); else n_pass++;
  endtask

  task automatic test_async_reset();
    rd_addr = {3'd0, 3'd2, 3'd6, 3'd5};
    iss_en = 2'b11; iss_addr = {3'd5, 3'd4};
    wr_en = 2'b11; wr_addr = {3'd0, 3'd2}; wr_data = {32'h9, 32'h2};
    step();
    idle();
    iss_en = 2'b11; iss_addr = {3'd7, 3'd6};
    step();
    idle();
    sb.push_back(128'hF0); sb.push_back({32'h9, 32'h2, 32'h66, 32'hDEADBEEF});
    e = sb.pop_front(); n_tot++; if (b_busy !== e[7:0]) $display("FAIL preload_busy: got %h expected %h", b_busy, e[7:0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (b_rd !== e) $display("FAIL preload_data: got %h expected %h", b_rd, e); else n_pass++;
    #2;
    wr_en = 2'b01; wr_addr[2:0] = 3'd5; wr_data[31:0] = 32'h1234;
    rst_n = 1'b0;
    sb.push_back(128'h0); sb.push_back(128'h0); sb.push_back(128'h0); sb.push_back(128'h0);
    #1;
    e = sb.pop_front(); n_tot++; if (b_rd !== e) $display("FAIL async_rd_data: got %h expected %h", b_rd, e); else n_pass++;
    e = sb.pop_front(); n_tot++; if (b_busy !== e[7:0]) $display("FAIL async_busy: got %h expected %h", b_busy, e[7:0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (b_rdb !== e[3:0]) $display("FAIL async_rd_busy: got %h expected %h", b_rdb, e[3:0]); else n_pass++;
    e = sb.pop_front(); n_tot++; if (b_col !== e[0]) $display("FAIL async_collision: got %b expected %b", b_col, e[0]); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(128'h0); sb.push_back(128'h1234);
    #1;
    e = sb.pop_front(); n_tot++; if (n_rd[31:0] !== e[31:0]) $display("FAIL release_before_edge: got %h expected %h", n_rd[31:0], e[31:0]); else n_pass++;
    step();
    idle();
    e = sb.pop_front(); n_tot++; if (n_rd[31:0] !== e[31:0]) $display("FAIL release_first_write: got %h expected %h", n_rd[31:0], e[31:0]); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_priority();
    test_scoreboard();
    test_set_clear();
    test_zero_r0();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
